// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / control unit.
package pipe_pkg;

  // Controller state: normal issue, or frozen waiting on data memory.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // EXE operand-mux selects.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of datapath-side signals seen by the hazard controller.
// Every signal is a level sampled by the datapath on the same rising edge;
// there is no valid/ready pairing: the controller answers combinationally
// each cycle and the datapath registers the answer on the next edge.
interface pipe_hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 32
);
  logic [ADDR_W-1:0] id_rs, id_rt;
  logic              id_uses_rs, id_uses_rt;
  logic [ADDR_W-1:0] ex_rs, ex_rt;
  logic              ex_mem_read;
  logic [ADDR_W-1:0] ex_wr_addr;
  logic              mem_reg_write, wb_reg_write;
  logic [ADDR_W-1:0] mem_wr_addr, wb_wr_addr;
  logic              branch_taken;
  logic              mem_req, mem_ready;
  logic [1:0]        fwd_a, fwd_b;
  logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic              ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic              mem_err;
  logic [CNT_W-1:0]  cycle_cnt, stall_cnt, flush_cnt;
  state_t            state;

  // Datapath side: drives pipeline status, receives control.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_mem_read,
           ex_wr_addr, mem_reg_write, wb_reg_write, mem_wr_addr, wb_wr_addr,
           branch_taken, mem_req, mem_ready,
    input  fwd_a, fwd_b, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_err,
           cycle_cnt, stall_cnt, flush_cnt, state
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_mem_read,
           ex_wr_addr, mem_reg_write, wb_reg_write, mem_wr_addr, wb_wr_addr,
           branch_taken, mem_req, mem_ready,
    output fwd_a, fwd_b, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_err,
           cycle_cnt, stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one EXE source register; MEM beats WB,
// register 0 is never forwarded.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              mem_reg_write,
  input  logic [ADDR_W-1:0] mem_wr_addr,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_wr_addr,
  input  logic [ADDR_W-1:0] src,
  output logic [1:0]        sel
);
  // Priority pick of the youngest in-flight producer.
  always_comb begin
    sel = FWD_REG;
    if (mem_reg_write && (mem_wr_addr == src) && (mem_wr_addr != '0))
      sel = FWD_MEM;
    else if (wb_reg_write && (wb_wr_addr == src) && (wb_wr_addr != '0))
      sel = FWD_WB;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stalls, branch squash,
// data-memory freeze with timeout, and performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state, state_nx;
  logic             pend_br, pend_nx;
  logic [7:0]       wait_cnt, wait_nx;
  logic             mem_err, err_nx;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
  logic             stall_inc, flush_inc, lu;
  logic [4:0]       en_v;  // {pc, ifid, idex, exmem, memwb}
  logic [3:0]       fl_v;  // {ifid, idex, exmem, memwb}
  logic [1:0]       sel_a, sel_b;

  fwd_unit #(.ADDR_W(ADDR_W)) u_fwd_a (
    .mem_reg_write(bus.mem_reg_write), .mem_wr_addr(bus.mem_wr_addr),
    .wb_reg_write(bus.wb_reg_write), .wb_wr_addr(bus.wb_wr_addr),
    .src(bus.ex_rs), .sel(sel_a)
  );

  fwd_unit #(.ADDR_W(ADDR_W)) u_fwd_b (
    .mem_reg_write(bus.mem_reg_write), .mem_wr_addr(bus.mem_wr_addr),
    .wb_reg_write(bus.wb_reg_write), .wb_wr_addr(bus.wb_wr_addr),
    .src(bus.ex_rt), .sel(sel_b)
  );

  assign lu = bus.ex_mem_read && (bus.ex_wr_addr != '0) &&
              ((bus.id_uses_rs && (bus.ex_wr_addr == bus.id_rs)) ||
               (bus.id_uses_rt && (bus.ex_wr_addr == bus.id_rt)));

  // Next state, enables/flushes and counter strobes; reset overrides outputs.
  always_comb begin
    state_nx  = state;
    pend_nx   = pend_br;
    wait_nx   = wait_cnt;
    err_nx    = mem_err;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    en_v      = 5'b11111;
    fl_v      = 4'b0000;
    case (state)
      RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          en_v     = 5'b00000;
          fl_v     = 4'b0001;
          state_nx = MEM_WAIT;
          wait_nx  = '0;
          if (bus.branch_taken) pend_nx = 1'b1;
        end else if (bus.branch_taken) begin
          fl_v      = 4'b1110;
          flush_inc = 1'b1;
        end else if (lu) begin
          en_v      = 5'b00111;
          fl_v      = 4'b0100;
          stall_inc = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A timeout completes the access exactly as mem_ready would.
        if (bus.mem_ready || (wait_cnt == WAIT_LAST)) begin
          state_nx = RUN;
          wait_nx  = '0;
          if (!bus.mem_ready) err_nx = 1'b1;
          if (pend_br) begin
            fl_v      = 4'b1110;
            flush_inc = 1'b1;
            pend_nx   = 1'b0;
          end
        end else begin
          en_v      = 5'b00000;
          fl_v      = 4'b0001;
          stall_inc = 1'b1;
          wait_nx   = wait_cnt + 8'd1;
        end
      end
      default: state_nx = RUN;
    endcase
    if (rst) begin
      en_v = 5'b00000;
      fl_v = 4'b1111;
    end
  end

  // State, pending-branch, wait counter and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pend_br  <= 1'b0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      pend_br  <= pend_nx;
      wait_cnt <= wait_nx;
      mem_err  <= err_nx;
    end
  end

  // Free-running performance counters, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.fwd_a       = rst ? FWD_REG : sel_a;
  assign bus.fwd_b       = rst ? FWD_REG : sel_b;
  assign bus.pc_en       = en_v[4];
  assign bus.ifid_en     = en_v[3];
  assign bus.idex_en     = en_v[2];
  assign bus.exmem_en    = en_v[1];
  assign bus.memwb_en    = en_v[0];
  assign bus.ifid_flush  = fl_v[3];
  assign bus.idex_flush  = fl_v[2];
  assign bus.exmem_flush = fl_v[1];
  assign bus.memwb_flush = fl_v[0];
  assign bus.mem_err     = mem_err;
  assign bus.cycle_cnt   = cycle_cnt;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;
  assign bus.state       = state;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic.
module tb_pipe_hazard_ctrl;
  localparam int MT = 4;
  localparam int W  = 14 + 96;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pipe_hazard_ctrl_if #(.ADDR_W(5), .CNT_W(32)) bus ();

  pipe_hazard_ctrl #(.ADDR_W(5), .CNT_W(32), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Clock.
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: access in progress, cycles spent on it so far.
  bit          m_busy, m_pend, m_err;
  int          m_age;
  logic [31:0] m_cyc, m_stall, m_flush;

  function automatic logic [1:0] fsel(logic mw, logic [4:0] ma, logic ww,
                                      logic [4:0] wa, logic [4:0] s);
    if (mw && ma == s && ma != 0) return 2'b10;
    if (ww && wa == s && wa != 0) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_in();
    bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_mem_read = 0; bus.ex_wr_addr = 0;
    bus.mem_reg_write = 0; bus.wb_reg_write = 0;
    bus.mem_wr_addr = 0; bus.wb_wr_addr = 0;
    bus.branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;
  endtask

  task automatic rand_in();
    bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
    bus.id_uses_rs = 1'($urandom); bus.id_uses_rt = 1'($urandom);
    bus.ex_rs = 5'($urandom_range(0, 3)); bus.ex_rt = 5'($urandom_range(0, 3));
    bus.ex_mem_read = 1'($urandom); bus.ex_wr_addr = 5'($urandom_range(0, 3));
    bus.mem_reg_write = 1'($urandom); bus.wb_reg_write = 1'($urandom);
    bus.mem_wr_addr = 5'($urandom_range(0, 3));
    bus.wb_wr_addr = 5'($urandom_range(0, 3));
    bus.branch_taken = ($urandom_range(0, 4) == 0);
    bus.mem_req = ($urandom_range(0, 2) == 0);
    bus.mem_ready = ($urandom_range(0, 9) < 6);
  endtask

  // Apply current inputs for one cycle: predict outputs, push, advance model.
  task automatic cycle();
    logic [1:0] fa, fb;
    logic [4:0] en;
    logic [3:0] fl;
    logic       lu;
    bit         si, fi;
    if (rst) begin
      exp_q.push_back({2'b00, 2'b00, 5'b00000, 4'b1111, 1'b0, 96'b0});
      m_busy = 0; m_pend = 0; m_err = 0; m_age = 0;
      m_cyc = 0; m_stall = 0; m_flush = 0;
    end else begin
      fa = fsel(bus.mem_reg_write, bus.mem_wr_addr, bus.wb_reg_write, bus.wb_wr_addr, bus.ex_rs);
      fb = fsel(bus.mem_reg_write, bus.mem_wr_addr, bus.wb_reg_write, bus.wb_wr_addr, bus.ex_rt);
      lu = bus.ex_mem_read && bus.ex_wr_addr != 0 &&
           ((bus.id_uses_rs && bus.ex_wr_addr == bus.id_rs) ||
            (bus.id_uses_rt && bus.ex_wr_addr == bus.id_rt));
      en = 5'b11111; fl = 4'b0000; si = 0; fi = 0;
      if (!m_busy) begin
        if (bus.mem_req && !bus.mem_ready) begin
          en = 0; fl = 4'b0001;
        end else if (bus.branch_taken) begin
          fl = 4'b1110; fi = 1;
        end else if (lu) begin
          en = 5'b00111; fl = 4'b0100; si = 1;
        end
      end else if (bus.mem_ready || m_age == MT) begin
        if (m_pend) begin fl = 4'b1110; fi = 1; end
      end else begin
        en = 0; fl = 4'b0001; si = 1;
      end
      exp_q.push_back({fa, fb, en, fl, m_err, m_cyc, m_stall, m_flush});
      // Advance the model.
      if (!m_busy) begin
        if (bus.mem_req && !bus.mem_ready) begin
          m_busy = 1; m_age = 1; m_pend = bus.branch_taken;
        end
      end else if (bus.mem_ready || m_age == MT) begin
        if (!bus.mem_ready) m_err = 1;
        m_busy = 0; m_pend = 0; m_age = 0;
      end else begin
        m_age++;
      end
      m_cyc++;
      if (si) m_stall++;
      if (fi) m_flush++;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [13:0]  act_ctrl;
    logic [95:0]  act_cnt;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act_ctrl = {bus.fwd_a, bus.fwd_b, bus.pc_en, bus.ifid_en, bus.idex_en,
                  bus.exmem_en, bus.memwb_en, bus.ifid_flush, bus.idex_flush,
                  bus.exmem_flush, bus.memwb_flush, bus.mem_err};
      act_cnt = {bus.cycle_cnt, bus.stall_cnt, bus.flush_cnt};
      total++;
      if (act_ctrl !== e[W-1:96]) begin
        bad++;
        $display("FAIL ctrl t=%0t got=%b want=%b", $time, act_ctrl, e[W-1:96]);
      end
      total++;
      if (act_cnt !== e[95:0]) begin
        bad++;
        $display("FAIL counters t=%0t got=%h want=%h", $time, act_cnt, e[95:0]);
      end
    end
  end

  // Stimulus sequence.
  initial begin
    clear_in();
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 0;
    // Forwarding: MEM beats WB; register 0 never forwarded.
    bus.mem_reg_write = 1; bus.mem_wr_addr = 3; bus.wb_reg_write = 1;
    bus.wb_wr_addr = 3; bus.ex_rs = 3; bus.ex_rt = 3; cycle();
    bus.mem_wr_addr = 0; bus.wb_wr_addr = 0; bus.ex_rs = 0; cycle();
    bus.mem_wr_addr = 7; bus.wb_wr_addr = 3; bus.ex_rs = 3; cycle();
    clear_in();
    // Load-use stall.
    bus.ex_mem_read = 1; bus.ex_wr_addr = 5; bus.id_rs = 5; bus.id_uses_rs = 1; cycle();
    clear_in(); cycle();
    // Load-use on r0 is ignored.
    bus.ex_mem_read = 1; bus.id_uses_rt = 1; cycle();
    // Branch together with load-use.
    bus.ex_wr_addr = 2; bus.id_rt = 2; bus.branch_taken = 1; cycle();
    clear_in(); cycle();
    // Memory completes immediately: no freeze.
    bus.mem_req = 1; bus.mem_ready = 1; cycle();
    // Freeze with a pending branch, three waiting cycles, then ready.
    bus.mem_ready = 0; bus.branch_taken = 1; cycle();
    bus.branch_taken = 0; cycle(); cycle(); cycle();
    bus.mem_ready = 1; cycle();
    clear_in(); cycle();
    // Timeout: memory never answers.
    bus.mem_req = 1; for (int i = 0; i < 6; i++) cycle();
    clear_in(); cycle(); cycle();
    // Reset in the middle of a freeze, then recount from zero.
    bus.mem_req = 1; bus.branch_taken = 1; cycle();
    bus.branch_taken = 0; cycle();
    rst = 1; cycle();
    rst = 0; bus.mem_req = 1; bus.mem_ready = 1; cycle();
    clear_in(); cycle(); cycle();
    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 0; clear_in(); cycle();
    @(negedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
